// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline-control unit: FSM state encodings,
// the hazard-cause priority ordering and the drain-length helper.
package pipe_ctrl_pkg;

    // Controller states; encodings are fixed so they stay stable in waveforms.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Hazard causes in RUN, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        CAUSE_NONE = 3'd0,
        CAUSE_MW   = 3'd1,
        CAUSE_LU   = 3'd2,
        CAUSE_JUMP = 3'd3,
        CAUSE_HALT = 3'd4
    } cause_t;

    // Smallest pipeline depth for which a halt drain makes sense.
    localparam int MIN_STAGES = 3;

    // Resolve simultaneous hazards: DMEM wait > load-use > jump > halt.
    function automatic cause_t pick_cause(input logic mw, input logic lu,
                                          input logic jump, input logic halt);
        cause_t c;
        if (mw)        c = CAUSE_MW;
        else if (lu)   c = CAUSE_LU;
        else if (jump) c = CAUSE_JUMP;
        else if (halt) c = CAUSE_HALT;
        else           c = CAUSE_NONE;
        return c;
    endfunction

    // In-flight instructions behind a HALT in ID: those in EX, MEM and WB.
    function automatic int drain_len(input int stages);
        return stages - 2;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// Holds at all-ones once reached; cleared only by rst.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Count up on inc, stick at the maximum value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline-control unit for the 16-bit 5-stage core.
// Arbitrates DMEM wait states, load-use stalls, jump flushes and
// halt-with-drain, and drives PC / pipeline-register enables, holds and
// flushes. All control outputs are combinational from state and inputs.
// Optional feature macro: PIPE_CTRL_PERF_EN enables the three saturating
// performance counters; without it the counter ports are tied to zero.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REGADDR_W = 4,
    parameter int STAGES    = 5,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [REGADDR_W-1:0] id_rs,
    input  logic [REGADDR_W-1:0] id_rt,
    input  logic                 id_use_rs,
    input  logic                 id_use_rt,
    input  logic                 id_is_jump,
    input  logic                 id_is_halt,
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic [REGADDR_W-1:0] ex_rd,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    input  logic                 resume,
    output logic                 pc_write,
    output logic                 pc_sel_jump,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_hold,
    output logic                 id_ex_flush,
    output logic                 ex_mem_hold,
    output logic                 mem_wb_bubble,
    output logic                 halted,
    output logic [CNT_W-1:0]     cnt_cycles,
    output logic [CNT_W-1:0]     cnt_stalls,
    output logic [CNT_W-1:0]     cnt_flushes
);

    localparam int DCNT_W = $clog2(STAGES + 1);
    localparam logic [DCNT_W-1:0] DRAIN_INIT = DCNT_W'(drain_len(STAGES));

    state_t              state;
    logic [DCNT_W-1:0]   drain_cnt;
    logic                mw;
    logic                lu;
    logic                rs_hit;
    logic                rt_hit;
    cause_t              cause;

    // A DMEM access that has not completed freezes the whole pipe.
    assign mw     = mem_req & ~mem_ready;
    // Load in EX whose destination is read by the real instruction in ID.
    assign rs_hit = id_use_rs & (id_rs == ex_rd);
    assign rt_hit = id_use_rt & (id_rt == ex_rd);
    assign lu     = ex_valid & ex_mem_read & id_valid & (rs_hit | rt_hit);
    assign cause  = pick_cause(mw, lu, id_valid & id_is_jump, id_valid & id_is_halt);

    // FSM: RUN -> DRAIN on HALT, DRAIN counts down the in-flight
    // instructions (frozen by DMEM waits), HALTED waits for resume.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (cause == CAUSE_HALT) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_INIT;
                    end
                end
                ST_DRAIN: begin
                    if (!mw) begin
                        if (drain_cnt == DCNT_W'(1)) begin
                            state     <= ST_HALTED;
                            drain_cnt <= '0;
                        end else begin
                            drain_cnt <= drain_cnt - DCNT_W'(1);
                        end
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    drain_cnt <= '0;
                end
            endcase
        end
    end

    // Decode enables, holds, flushes and bubbles from state and hazards.
    always_comb begin
        pc_write      = 1'b0;
        pc_sel_jump   = 1'b0;
        if_id_write   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_hold    = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_hold   = 1'b0;
        mem_wb_bubble = 1'b0;
        halted        = 1'b0;
        if (reset) begin
            // Keep bubbles flowing into the front of the pipe during reset.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    case (cause)
                        CAUSE_MW: begin
                            id_ex_hold    = 1'b1;
                            ex_mem_hold   = 1'b1;
                            mem_wb_bubble = 1'b1;
                        end
                        CAUSE_LU: begin
                            id_ex_flush = 1'b1;
                        end
                        CAUSE_JUMP: begin
                            pc_write    = 1'b1;
                            pc_sel_jump = 1'b1;
                            if_id_flush = 1'b1;
                            id_ex_flush = 1'b1;
                        end
                        CAUSE_HALT: begin
                            id_ex_flush = 1'b1;
                        end
                        default: begin
                            pc_write    = 1'b1;
                            if_id_write = 1'b1;
                        end
                    endcase
                end
                ST_DRAIN: begin
                    if (mw) begin
                        id_ex_hold    = 1'b1;
                        ex_mem_hold   = 1'b1;
                        mem_wb_bubble = 1'b1;
                    end else begin
                        id_ex_flush = 1'b1;
                    end
                end
                ST_HALTED: begin
                    halted      = 1'b1;
                    id_ex_flush = 1'b1;
                end
                default: begin
                    id_ex_flush = 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic stall_evt;
    logic flush_evt;

    assign stall_evt = mw | lu;
    assign flush_evt = (state == ST_RUN) & if_id_flush;

    sat_counter #(.CNT_W(CNT_W)) u_cnt_cycles (
        .clk (clk),
        .rst (reset),
        .inc (1'b1),
        .cnt (cnt_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_stalls (
        .clk (clk),
        .rst (reset),
        .inc (stall_evt),
        .cnt (cnt_stalls)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_flushes (
        .clk (clk),
        .rst (reset),
        .inc (flush_evt),
        .cnt (cnt_flushes)
    );
`else
    assign cnt_cycles  = '0;
    assign cnt_stalls  = '0;
    assign cnt_flushes = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural reference model.
module tb_pipe_ctrl;

    localparam int RW     = 4;
    localparam int STG    = 5;
    localparam int CW     = 4;
    localparam int CMAX   = (1 << CW) - 1;

    typedef struct packed {
        logic pc_write;
        logic pc_sel_jump;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_hold;
        logic id_ex_flush;
        logic ex_mem_hold;
        logic mem_wb_bubble;
        logic halted;
    } ctl_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          id_valid = 1'b0;
    logic [RW-1:0] id_rs = '0;
    logic [RW-1:0] id_rt = '0;
    logic          id_use_rs = 1'b0;
    logic          id_use_rt = 1'b0;
    logic          id_is_jump = 1'b0;
    logic          id_is_halt = 1'b0;
    logic          ex_valid = 1'b0;
    logic          ex_mem_read = 1'b0;
    logic [RW-1:0] ex_rd = '0;
    logic          mem_req = 1'b0;
    logic          mem_ready = 1'b0;
    logic          resume = 1'b0;
    logic          pc_write, pc_sel_jump, if_id_write, if_id_flush;
    logic          id_ex_hold, id_ex_flush, ex_mem_hold, mem_wb_bubble, halted;
    logic [CW-1:0] cnt_cycles, cnt_stalls, cnt_flushes;

    ctl_t got;
    assign got = '{pc_write, pc_sel_jump, if_id_write, if_id_flush, id_ex_hold,
                   id_ex_flush, ex_mem_hold, mem_wb_bubble, halted};

    // Reference patterns straight from the control table.
    localparam ctl_t P_RESET  = '{0,0,0,1,0,1,0,0,0};
    localparam ctl_t P_RUN    = '{1,0,1,0,0,0,0,0,0};
    localparam ctl_t P_FREEZE = '{0,0,0,0,1,0,1,1,0};
    localparam ctl_t P_BUBBLE = '{0,0,0,0,0,1,0,0,0};
    localparam ctl_t P_JUMP   = '{1,1,0,1,0,1,0,0,0};
    localparam ctl_t P_HALTED = '{0,0,0,0,0,1,0,0,1};

    int errors = 0;
    int checks = 0;

    // Behavioural model state.
    logic m_halted = 1'b0;
    int   m_drain_left = 0;
    int   m_cycles = 0, m_stalls = 0, m_flushes = 0;

    pipe_ctrl #(.REGADDR_W(RW), .STAGES(STG), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_jump(id_is_jump),
        .id_is_halt(id_is_halt), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .mem_req(mem_req), .mem_ready(mem_ready), .resume(resume),
        .pc_write(pc_write), .pc_sel_jump(pc_sel_jump), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_hold(id_ex_hold), .id_ex_flush(id_ex_flush),
        .ex_mem_hold(ex_mem_hold), .mem_wb_bubble(mem_wb_bubble), .halted(halted),
        .cnt_cycles(cnt_cycles), .cnt_stalls(cnt_stalls), .cnt_flushes(cnt_flushes)
    );

    always #5 clk = ~clk;

    function automatic logic f_mw();
        return mem_req & ~mem_ready;
    endfunction

    function automatic logic f_lu();
        return ex_valid & ex_mem_read & id_valid &
               ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
    endfunction

    function automatic ctl_t model_ctl();
        ctl_t c;
        if (reset)                          c = P_RESET;
        else if (m_halted)                  c = P_HALTED;
        else if (f_mw())                    c = P_FREEZE;
        else if (m_drain_left > 0 || f_lu()) c = P_BUBBLE;
        else if (id_valid && id_is_jump)    c = P_JUMP;
        else if (id_valid && id_is_halt)    c = P_BUBBLE;
        else                                c = P_RUN;
        return c;
    endfunction

    function automatic logic [3*CW-1:0] model_cnt();
`ifdef PIPE_CTRL_PERF_EN
        return {CW'(m_cycles), CW'(m_stalls), CW'(m_flushes)};
`else
        return '0;
`endif
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Reference model: advance halt/drain bookkeeping and event counts.
    always @(posedge clk) begin
        if (reset) begin
            m_halted <= 1'b0;
            m_drain_left <= 0;
            m_cycles <= 0;
            m_stalls <= 0;
            m_flushes <= 0;
        end else begin
            if (m_halted) begin
                if (resume) m_halted <= 1'b0;
            end else if (m_drain_left > 0) begin
                if (!f_mw()) begin
                    m_drain_left <= m_drain_left - 1;
                    if (m_drain_left == 1) m_halted <= 1'b1;
                end
            end else if (!f_mw() && !f_lu() && id_valid && id_is_halt) begin
                m_drain_left <= STG - 2;
            end
            m_cycles <= sat_inc(m_cycles);
            if (f_mw() || f_lu()) m_stalls <= sat_inc(m_stalls);
            if (!m_halted && m_drain_left == 0 && !f_mw() && !f_lu() && id_valid && id_is_jump)
                m_flushes <= sat_inc(m_flushes);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_is_jump = 1'b0; id_is_halt = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0;
        ex_rd = '0; mem_req = 1'b0; mem_ready = 1'b0; resume = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        checks++;
        if (got !== P_RESET) begin
            errors++; $display("FAIL reset_outputs got=%b want=%b", got, P_RESET);
        end
        checks++;
        if ({cnt_cycles, cnt_stalls, cnt_flushes} !== '0) begin
            errors++; $display("FAIL reset_counters got=%h want=0", {cnt_cycles, cnt_stalls, cnt_flushes});
        end
        cyc();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (got !== P_RUN) begin
            errors++; $display("FAIL run_default got=%b want=%b", got, P_RUN);
        end
        cyc();
    endtask

    task automatic test_load_use();
        int stall_cycles = 0;
        id_valid = 1'b1; id_rs = 4'd3; id_use_rs = 1'b1;
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 4'd3;
        @(negedge clk);
        checks++;
        if (got !== P_BUBBLE) begin
            errors++; $display("FAIL load_use_stall got=%b want=%b", got, P_BUBBLE);
        end
        if (!pc_write) stall_cycles++;
        cyc();
        // The load moved on; a bubble now sits in EX.
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        @(negedge clk);
        if (!pc_write) stall_cycles++;
        checks++;
        if (stall_cycles !== 1 || got !== P_RUN) begin
            errors++; $display("FAIL load_use_release stalls=%0d got=%b want 1 / %b", stall_cycles, got, P_RUN);
        end
        cyc();
        idle_inputs();
    endtask

    task automatic test_mem_wait();
        int frozen = 0;
        id_valid = 1'b1;
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (got === P_FREEZE) frozen++;
            cyc();
        end
        checks++;
        if (frozen !== 4) begin
            errors++; $display("FAIL mem_wait_freeze frozen=%0d want=4", frozen);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (got !== P_RUN) begin
            errors++; $display("FAIL mem_wait_release got=%b want=%b", got, P_RUN);
        end
        cyc();
        idle_inputs();
    endtask

    task automatic test_jump_after_lu();
        id_valid = 1'b1; id_is_jump = 1'b1; id_rt = 4'd7; id_use_rt = 1'b1;
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 4'd7;
        @(negedge clk);
        checks++;
        if (got !== P_BUBBLE) begin
            errors++; $display("FAIL jump_lu_stall got=%b want=%b", got, P_BUBBLE);
        end
        cyc();
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        @(negedge clk);
        checks++;
        if (got !== P_JUMP) begin
            errors++; $display("FAIL jump_flush got=%b want=%b", got, P_JUMP);
        end
        cyc();
        idle_inputs();
    endtask

    // Present HALT for one cycle, then count edges until halted rises.
    task automatic run_halt(input int mw_cycles, output int edges);
        id_valid = 1'b1; id_is_halt = 1'b1;
        @(negedge clk);
        checks++;
        if (got !== P_BUBBLE) begin
            errors++; $display("FAIL halt_in_id got=%b want=%b", got, P_BUBBLE);
        end
        cyc();
        idle_inputs();
        mem_req = (mw_cycles > 0);
        if (mw_cycles > 0) begin
            @(negedge clk);
            checks++;
            if (got !== P_FREEZE) begin
                errors++; $display("FAIL drain_freeze got=%b want=%b", got, P_FREEZE);
            end
        end
        edges = 0;
        while (edges < 20) begin
            cyc();
            edges++;
            mem_req = (edges < mw_cycles);
            if (halted === 1'b1) break;
        end
        mem_req = 1'b0;
    endtask

    task automatic test_halt_resume();
        int edges;
        run_halt(0, edges);
        checks++;
        if (edges !== STG - 2) begin
            errors++; $display("FAIL halt_latency edges=%0d want=%0d", edges, STG - 2);
        end
        resume = 1'b1;
        @(negedge clk);
        checks++;
        if (got !== P_HALTED) begin
            errors++; $display("FAIL halted_outputs got=%b want=%b", got, P_HALTED);
        end
        cyc();
        resume = 1'b0;
        @(negedge clk);
        checks++;
        if (got !== P_RUN) begin
            errors++; $display("FAIL resume_run got=%b want=%b", got, P_RUN);
        end
        cyc();
        run_halt(2, edges);
        checks++;
        if (edges !== STG) begin
            errors++; $display("FAIL halt_latency_mw edges=%0d want=%0d", edges, STG);
        end
        resume = 1'b1;
        cyc();
        resume = 1'b0;
        cyc();
        // Resume while running must be ignored.
        resume = 1'b1;
        @(negedge clk);
        checks++;
        if (got !== P_RUN) begin
            errors++; $display("FAIL resume_in_run got=%b want=%b", got, P_RUN);
        end
        cyc();
        resume = 1'b0;
        @(negedge clk);
        checks++;
        if (got !== P_RUN) begin
            errors++; $display("FAIL resume_in_run_next got=%b want=%b", got, P_RUN);
        end
        cyc();
    endtask

    task automatic test_perf();
        logic [CW-1:0] want_cycles;
        int edges;
        idle_inputs();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        repeat (20) cyc();
`ifdef PIPE_CTRL_PERF_EN
        want_cycles = CW'(CMAX);
`else
        want_cycles = '0;
`endif
        @(negedge clk);
        checks++;
        if (cnt_cycles !== want_cycles || cnt_stalls !== '0 || cnt_flushes !== '0) begin
            errors++; $display("FAIL perf_saturate cycles=%0d stalls=%0d flushes=%0d want %0d/0/0",
                               cnt_cycles, cnt_stalls, cnt_flushes, want_cycles);
        end
        cyc();
        // Reset in the middle of a drain.
        id_valid = 1'b1; id_is_halt = 1'b1;
        cyc();
        idle_inputs();
        cyc();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (got !== P_RESET) begin
            errors++; $display("FAIL reset_in_drain got=%b want=%b", got, P_RESET);
        end
        cyc();
        @(negedge clk);
        checks++;
        if ({cnt_cycles, cnt_stalls, cnt_flushes} !== '0) begin
            errors++; $display("FAIL reset_clears_counters got=%h want=0", {cnt_cycles, cnt_stalls, cnt_flushes});
        end
        cyc();
        reset = 1'b0;
        edges = 0;
        repeat (5) begin
            @(negedge clk);
            if (got !== P_RUN) edges++;
            cyc();
        end
        checks++;
        if (edges !== 0) begin
            errors++; $display("FAIL drain_cleared non_run_cycles=%0d want=0", edges);
        end
    endtask

    task automatic test_random();
        ctl_t want;
        logic [3*CW-1:0] want_cnt;
        int  sel;
        for (int n = 0; n < 400; n++) begin
            reset       = ($urandom_range(0, 99) < 2);
            id_valid    = ($urandom_range(0, 99) < 80);
            sel         = $urandom_range(0, 99);
            id_is_jump  = (sel < 10);
            id_is_halt  = (sel >= 10 && sel < 16);
            id_rs       = RW'($urandom_range(0, 3));
            id_rt       = RW'($urandom_range(0, 3));
            id_use_rs   = $urandom_range(0, 1) != 0;
            id_use_rt   = $urandom_range(0, 1) != 0;
            ex_valid    = ($urandom_range(0, 99) < 70);
            ex_mem_read = ($urandom_range(0, 99) < 30);
            ex_rd       = RW'($urandom_range(0, 3));
            mem_req     = ($urandom_range(0, 99) < 30);
            mem_ready   = $urandom_range(0, 1) != 0;
            resume      = ($urandom_range(0, 99) < 15);
            @(negedge clk);
            want     = model_ctl();
            want_cnt = model_cnt();
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL random_ctl cycle=%0d got=%b want=%b", n, got, want);
            end
            checks++;
            if ({cnt_cycles, cnt_stalls, cnt_flushes} !== want_cnt) begin
                errors++; $display("FAIL random_cnt cycle=%0d got=%h want=%h", n,
                                   {cnt_cycles, cnt_stalls, cnt_flushes}, want_cnt);
            end
            cyc();
        end
        idle_inputs();
        reset = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_load_use();
        test_mem_wait();
        test_jump_after_lu();
        test_halt_resume();
        test_perf();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
